// File: rtl/nonconsec_rep_checker.sv
// Runtime checker for (a ##1 b[=REP_COUNT]) |-> c with a table of overlapping attempts.
// Reports per-cycle pass/fail/drop pulses, live slot count and saturating statistics.
module nonconsec_rep_checker #(
  parameter int unsigned REP_COUNT = 3,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           a_i,
  input  logic                           b_i,
  input  logic                           c_i,
  output logic                           pass_pulse_o,
  output logic                           fail_pulse_o,
  output logic                           ovf_pulse_o,
  output logic [$clog2(NUM_SLOTS+1)-1:0] active_o,
  output logic [CNT_W-1:0]               pass_cnt_o,
  output logic [CNT_W-1:0]               fail_cnt_o,
  output logic [CNT_W-1:0]               drop_cnt_o
);

  localparam int unsigned CW   = $clog2(REP_COUNT + 2);
  localparam int unsigned AW   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned SumW = ((CNT_W > AW) ? CNT_W : AW) + 1;
  localparam logic [CW-1:0] RepC = CW'(REP_COUNT);

  logic [NUM_SLOTS-1:0]         valid_q, valid_d;
  logic [NUM_SLOTS-1:0]         ok_q, ok_d;
  logic [NUM_SLOTS-1:0][CW-1:0] cnt_q, cnt_d;

  logic             pass_pulse_q, fail_pulse_q, ovf_pulse_q;
  logic [AW-1:0]    active_q, active_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [NUM_SLOTS-1:0] pass_vec, fail_vec;
  logic                 drop;
  logic                 found;
  logic [CW-1:0]        cnt_inc;
  logic [AW-1:0]        pass_n, fail_n;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [AW-1:0]    inc);
    logic [SumW-1:0] sum;
    sum = SumW'(base) + SumW'(inc);
    if (sum > SumW'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  // Slot evaluation first, then allocation so that same-cycle retirements free their slot.
  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    ok_d     = ok_q;
    pass_vec = '0;
    fail_vec = '0;
    drop     = 1'b0;
    found    = 1'b0;
    cnt_inc  = '0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt_inc = cnt_q[i] + 1'b1;
      if (valid_q[i]) begin
        if (cnt_q[i] != RepC) begin
          if (b_i) begin
            cnt_d[i] = cnt_inc;
            if ((cnt_inc == RepC) && !c_i) begin
              fail_vec[i] = 1'b1;
              valid_d[i]  = 1'b0;
            end
          end
        end else if (b_i) begin
          // Extra b closes the attempt without looking at c.
          valid_d[i]  = 1'b0;
          pass_vec[i] = ok_q[i];
          fail_vec[i] = ~ok_q[i];
        end else if (!c_i) begin
          fail_vec[i] = 1'b1;
          valid_d[i]  = 1'b0;
        end
      end
    end

    if (a_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!found && !valid_d[i]) begin
          found      = 1'b1;
          valid_d[i] = 1'b1;
          cnt_d[i]   = '0;
          ok_d[i]    = 1'b1;
        end
      end
      drop = ~found;
    end

    if (!en_i) begin
      valid_d  = '0;
      pass_vec = '0;
      fail_vec = '0;
      drop     = 1'b0;
    end
  end

  always_comb begin
    pass_n   = '0;
    fail_n   = '0;
    active_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pass_n   = pass_n + AW'(pass_vec[i]);
      fail_n   = fail_n + AW'(fail_vec[i]);
      active_d = active_d + AW'(valid_d[i]);
    end
    pass_cnt_d = sat_add(pass_cnt_q, pass_n);
    fail_cnt_d = sat_add(fail_cnt_q, fail_n);
    drop_cnt_d = sat_add(drop_cnt_q, AW'(drop));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      ok_q         <= '0;
      cnt_q        <= '0;
      pass_pulse_q <= 1'b0;
      fail_pulse_q <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      active_q     <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      ok_q         <= ok_d;
      cnt_q        <= cnt_d;
      pass_pulse_q <= |pass_vec;
      fail_pulse_q <= |fail_vec;
      ovf_pulse_q  <= drop;
      active_q     <= active_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign pass_pulse_o = pass_pulse_q;
  assign fail_pulse_o = fail_pulse_q;
  assign ovf_pulse_o  = ovf_pulse_q;
  assign active_o     = active_q;
  assign pass_cnt_o   = pass_cnt_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_nonconsec_rep_checker.sv
// Directed bench for nonconsec_rep_checker (REP_COUNT=3, NUM_SLOTS=4).
module tb_nonconsec_rep_checker;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, a_i, b_i, c_i;
  logic        pass_pulse_o, fail_pulse_o, ovf_pulse_o;
  logic [2:0]  active_o;
  logic [15:0] pass_cnt_o, fail_cnt_o, drop_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  nonconsec_rep_checker #(
    .REP_COUNT(3),
    .NUM_SLOTS(4),
    .CNT_W    (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .c_i         (c_i),
    .pass_pulse_o(pass_pulse_o),
    .fail_pulse_o(fail_pulse_o),
    .ovf_pulse_o (ovf_pulse_o),
    .active_o    (active_o),
    .pass_cnt_o  (pass_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply inputs for one cycle, then land 1 time unit after the closing edge.
  task automatic cyc(input logic a, input logic b, input logic c);
    a_i = a;
    b_i = b;
    c_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string tag, input int pp, input int fp, input int op,
                         input int act, input int pc, input int fc, input int dc);
    chk({tag, ".pass_pulse"}, int'(pass_pulse_o), pp);
    chk({tag, ".fail_pulse"}, int'(fail_pulse_o), fp);
    chk({tag, ".ovf_pulse"},  int'(ovf_pulse_o),  op);
    chk({tag, ".active"},     int'(active_o),     act);
    chk({tag, ".pass_cnt"},   int'(pass_cnt_o),   pc);
    chk({tag, ".fail_cnt"},   int'(fail_cnt_o),   fc);
    chk({tag, ".drop_cnt"},   int'(drop_cnt_o),   dc);
  endtask

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b1;
    a_i   = 1'b0;
    b_i   = 1'b0;
    c_i   = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    cyc(0, 0, 0);

    // Basic pass: a@0, b@1,3,5, c=1, closing b@7
    cyc(1, 0, 1);
    chk("basic.active_alloc", int'(active_o), 1);
    cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1);
    chk("basic.no_early_pass", int'(pass_pulse_o), 0);
    chk("basic.active_hold", int'(active_o), 1);
    cyc(0, 1, 1);
    chk_all("basic.pass", 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1);
    chk("basic.pulse_width", int'(pass_pulse_o), 0);

    // Fail on entry: c=0 at the third b
    cyc(1, 0, 1);
    cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk_all("entry.fail", 0, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 1);
    chk("entry.pulse_width", int'(fail_pulse_o), 0);
    cyc(0, 1, 1);
    chk("entry.no_late_pass", int'(pass_pulse_o), 0);
    chk("entry.pass_cnt", int'(pass_cnt_o), 1);

    // Fail in hold window: c=0 at cycle 6
    cyc(1, 0, 1);
    cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk_all("hold.fail", 0, 1, 0, 0, 1, 2, 0);
    cyc(0, 1, 1);
    chk("hold.no_pass", int'(pass_pulse_o), 0);
    chk("hold.no_refail", int'(fail_pulse_o), 0);

    // Overlap: a@0,2; b@1,3,4,6; second pass on b@9
    cyc(1, 0, 1); cyc(0, 1, 1); cyc(1, 0, 1);
    chk("ovl.active2", int'(active_o), 2);
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 1, 1);
    chk_all("ovl.pass1", 1, 0, 0, 1, 2, 2, 0);
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("ovl.gap", int'(pass_pulse_o), 0);
    cyc(0, 1, 1);
    chk_all("ovl.pass2", 1, 0, 0, 0, 3, 2, 0);

    // Simultaneous pass of two slots plus allocation into a freed slot
    cyc(1, 0, 1); cyc(1, 0, 1);
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk_all("dual.pass", 1, 0, 0, 1, 5, 2, 0);
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    chk("dual.new_slot_ignores_b", int'(pass_pulse_o), 0);
    chk("dual.active_new", int'(active_o), 1);
    cyc(0, 1, 1);
    chk_all("dual.new_pass", 1, 0, 0, 0, 6, 2, 0);

    // Overflow: a held for five cycles with four slots
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
    chk_all("ovf.full", 0, 0, 0, 4, 6, 2, 0);
    cyc(1, 0, 1);
    chk_all("ovf.drop", 0, 0, 1, 4, 6, 2, 1);
    cyc(0, 0, 1);
    chk("ovf.pulse_width", int'(ovf_pulse_o), 0);

    // Disable clears slots silently and holds counters
    en_i = 1'b0;
    cyc(1, 1, 0);
    chk_all("dis.clear", 0, 0, 0, 0, 6, 2, 1);
    en_i = 1'b1;
    cyc(0, 0, 0);
    chk_all("dis.after", 0, 0, 0, 0, 6, 2, 1);

    // Reset mid-attempt
    cyc(1, 0, 1); cyc(0, 1, 1);
    rst_i = 1'b1;
    cyc(0, 0, 0);
    chk_all("rst.mid", 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/nonconsec_rep_checker.md
# nonconsec_rep_checker

Synthesizable runtime checker for the non-consecutive repetition rule "trigger `a`, then exactly REP_COUNT non-consecutive `b` pulses, implies `c`" (SVA equivalent `(a ##1 b[=REP_COUNT]) |-> c`). It tracks up to NUM_SLOTS overlapping attempts in a slot table and reports per-attempt pass/fail. It also keeps saturating statistics. It sits beside the monitored datapath as an on-chip assertion engine and feeds the status/debug register bank.

## Interface
- REP_COUNT, 3, number of `b` pulses required after the trigger (≥1)
- NUM_SLOTS, 4, maximum concurrently tracked attempts (1..16)
- CNT_W, 16, width of statistic counters
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  checker enable; low = disable (acts like `disable iff`)
- a  in  1  trigger
- b  in  1  counted event
- c  in  1  consequent
- pass_pulse  out  1  ≥1 attempt passed in the previous cycle
- fail_pulse  out  1  ≥1 attempt failed in the previous cycle
- ovf_pulse  out  1  a trigger was dropped in the previous cycle (no free slot)
- active  out  $clog2(NUM_SLOTS+1)  number of live slots
- pass_cnt  out  CNT_W  total passed attempts, saturating
- fail_cnt  out  CNT_W  total failed attempts, saturating
- drop_cnt  out  CNT_W  total dropped triggers, saturating

## Operation
- Each slot holds `valid`, `cnt` (width $clog2(REP_COUNT+2)) and `ok`.
- Slot states: FREE (`valid`=0); COUNT (`cnt`<REP_COUNT); CHECK (`cnt`==REP_COUNT).
- Allocation: `a`=1 with `en`=1 in cycle t claims the lowest-index free slot with `cnt`=0, `ok`=1. The `b` value in cycle t is not counted. Evaluation starts in cycle t+1.
- Per valid slot, each cycle with `en`=1:
  - COUNT, `b`=1: `cnt`+1. If the new count equals REP_COUNT, the slot enters CHECK and `c` is checked in this same cycle.
  - CHECK, `b`=0: `c` is checked.
  - CHECK, `b`=1: this is the (REP_COUNT+1)th `b`. `c` is not checked. The slot retires as pass if `ok`=1.
  - Any `c` check with `c`=0: the slot retires as fail immediately. Each attempt fails at most once.
- Slots retiring in cycle t count as free for an allocation in cycle t.
- No free slot when `a`=1: the trigger is dropped; `ovf_pulse` and `drop_cnt` update.
- A trigger in the same cycle as the evaluation of other slots is independent of them. New slots never see that cycle's `b`.
- Simultaneous retirements: the pulse is a single bit. `pass_cnt`/`fail_cnt` add the popcount of slots retiring that cycle and saturate at all-ones.
- `en`=0: all slots cleared to FREE, no allocation, no pulses. Counters hold.
- Attempts never closed by a further `b` stay in CHECK indefinitely and are not reported.

## Timing
- Reset: all slots FREE. `pass_pulse`=`fail_pulse`=`ovf_pulse`=0, `active`=0, all counters 0.
- `rst` has priority over `en` and all inputs.
- All outputs are registered. An event evaluated in cycle t is visible after the edge ending cycle t, i.e. in cycle t+1.
- Pulses are exactly one cycle wide per event cycle. Back-to-back event cycles give back-to-back pulses.
- `active` reflects the slot table after the same edge, including new allocations and retirements.
- Reset or disable mid-attempt discards the attempt silently, with no fail reported.

## Test plan
- Basic pass (REP_COUNT=3): `a`@0; `b`@1,3,5; `c`=1 at 5,6; `b`@7 → `pass_pulse`@8, `pass_cnt`=1, `active` 1→0 @8.
- Fail on entry: same stimulus but `c`=0 at cycle 5 → `fail_pulse`@6, `fail_cnt`=1, slot freed @6. The later `b`@7 produces no pass.
- Fail in hold window: `c`=1 @5, `c`=0 @6, `b`@7 → `fail_pulse`@7 only, no pass.
- Overlap: `a`@0 and `a`@2; `b`@1,3,4,6; `c`=1 throughout → slot0 completes on `b`@4 and passes on `b`@6 (`pass_pulse`@7). Slot1 counts `b`@3,4,6 and stays in CHECK, so `active`=1 @7. A further `b`@9 gives a second pass @10, `pass_cnt`=2.
- Overflow (NUM_SLOTS=4): `a`=1 for cycles 0–4, `b`=0 → `active`=4 @4, `ovf_pulse`@5, `drop_cnt`=1.
- Reset/disable mid-operation: `a`@0, `b`@1, `rst`@2 → all outputs 0 @3. Repeat with `en`=0 @2: slots cleared, counters unchanged, no pulses.
